// File: rtl/sram_word_controller_if.sv
// Cache-side word request/response bundle for sram_word_controller.
// The cache holds read_req/write_req until the one-cycle ready pulse.
interface sram_word_controller_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  read_req;
    logic                  write_req;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] writedata;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  ready;

    modport master (
        output read_req, write_req, address, writedata,
        input  readdata, ready
    );

    modport slave (
        input  read_req, write_req, address, writedata,
        output readdata, ready
    );
endinterface

// File: rtl/sram_word_controller.sv
// One cache word as two 16-bit async SRAM accesses, low half first; SRAM_WRITE_FWD_EN adds a last-write forwarding buffer.
// Ready pulses 2*(WAIT_CYCLES+1)+1 edges after acceptance (1 on a forwarded read); requests are held until ready.
module sram_word_controller #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_word_controller_if.slave bus,
    output logic [17:0]           sram_addr,
    inout  wire  [15:0]           sram_dq,
    output logic                  sram_we_n,
    output logic                  sram_oe_n,
    output logic                  sram_ce_n,
    output logic                  sram_ub_n,
    output logic                  sram_lb_n
);
    localparam int         HW   = DATA_WIDTH / 2;
    localparam int         PAD  = 17 - ADDR_WIDTH;
    localparam logic [3:0] LAST = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  accept;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_word;
    logic                  op_wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  phase;
    logic                  half;
    logic                  drive;

`ifdef SRAM_WRITE_FWD_EN
    logic                  fwd_vld_q;
    logic [ADDR_WIDTH-1:0] fwd_addr_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;

    // A simultaneous write wins, so only a pure read may bypass the SRAM.
    assign fwd_hit  = fwd_vld_q && bus.read_req && !bus.write_req && (bus.address == fwd_addr_q);
    assign fwd_word = fwd_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_vld_q  <= 1'b0;
            fwd_addr_q <= '0;
            fwd_data_q <= '0;
        end else if (accept && bus.write_req) begin
            fwd_vld_q  <= 1'b1;
            fwd_addr_q <= bus.address;
            fwd_data_q <= bus.writedata;
        end
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_word = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.write_req || bus.read_req) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = fwd_hit ? DONE : LOW;
                end
            end
            LOW: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = HIGH;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HIGH: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode from registered state only; count 0 of a write phase is address setup.
    always_comb begin
        phase     = (state_q == LOW) || (state_q == HIGH);
        half      = (state_q == HIGH);
        drive     = phase && op_wr_q;
        sram_ce_n = !phase;
        sram_ub_n = !phase;
        sram_lb_n = !phase;
        sram_oe_n = !(phase && !op_wr_q);
        sram_we_n = !(drive && (cnt_q != 4'd0));
        sram_addr = phase ? {{PAD{1'b0}}, addr_q, half} : 18'd0;
    end

    assign sram_dq      = drive ? (half ? wdata_q[DATA_WIDTH-1:HW] : wdata_q[HW-1:0]) : 16'hzzzz;
    assign bus.ready    = (state_q == DONE);
    assign bus.readdata = rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                op_wr_q <= bus.write_req;
                addr_q  <= bus.address;
                wdata_q <= bus.writedata;
            end
            if (accept && fwd_hit) begin
                rdata_q <= fwd_word;
            end
            if (!op_wr_q && (cnt_q == LAST)) begin
                if (state_q == LOW)  rdata_q[HW-1:0]          <= sram_dq;
                if (state_q == HIGH) rdata_q[DATA_WIDTH-1:HW] <= sram_dq;
            end
        end
    end
endmodule

// File: tb/tb_sram_word_controller.sv
// Randomized scoreboard bench: two controllers (WAIT_CYCLES 1 and 3) against behavioural SRAM and word models.
module tb_sram_word_controller;
    localparam int W0 = 1;
    localparam int W1 = 3;
`ifdef SRAM_WRITE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk;
    logic rst;

    sram_word_controller_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus0 ();
    sram_word_controller_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus1 ();

    logic        rreq [2];
    logic        wreq [2];
    logic [15:0] areq [2];
    logic [31:0] dreq [2];

    assign bus0.read_req  = rreq[0];
    assign bus0.write_req = wreq[0];
    assign bus0.address   = areq[0];
    assign bus0.writedata = dreq[0];
    assign bus1.read_req  = rreq[1];
    assign bus1.write_req = wreq[1];
    assign bus1.address   = areq[1];
    assign bus1.writedata = dreq[1];

    logic [17:0] sa0, sa1;
    logic        we0, oe0, ce0, ub0, lb0;
    logic        we1, oe1, ce1, ub1, lb1;
    wire  [15:0] dq0, dq1;
    logic [15:0] rdv0, rdv1;

    // The SRAM model drives the bus only while chip and output enable are low.
    assign dq0 = (!ce0 && !oe0) ? rdv0 : 16'hzzzz;
    assign dq1 = (!ce1 && !oe1) ? rdv1 : 16'hzzzz;

    sram_word_controller #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .WAIT_CYCLES(W0)) u0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .sram_addr(sa0), .sram_dq(dq0), .sram_we_n(we0), .sram_oe_n(oe0),
        .sram_ce_n(ce0), .sram_ub_n(ub0), .sram_lb_n(lb0)
    );

    sram_word_controller #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .WAIT_CYCLES(W1)) u1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .sram_addr(sa1), .sram_dq(dq1), .sram_we_n(we1), .sram_oe_n(oe1),
        .sram_ce_n(ce1), .sram_ub_n(ub1), .sram_lb_n(lb1)
    );

    typedef struct {
        int          d;
        bit          wr;
        logic [15:0] addr;
        logic [31:0] data;
        int          lat;
        int          oe;
        int          we;
        int          wep;
        int          acc;
    } exp_t;

    exp_t        q [$];
    logic [15:0] mem [int];
    logic [15:0] ref_half [int];
    bit          fwd_v [2];
    logic [15:0] fwd_a [2];
    logic [31:0] fwd_d [2];
    int          errors = 0;
    int          checks = 0;
    int          edge_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            edge_cnt++;
        end
    end

    function automatic int key(int d, logic [15:0] a, int h);
        return (d << 18) | (int'(a) << 1) | h;
    endfunction

    function automatic logic [15:0] mem_rd(int k);
        return mem.exists(k) ? mem[k] : 16'h0000;
    endfunction

    function automatic logic [15:0] ref_rd(int k);
        return ref_half.exists(k) ? ref_half[k] : 16'h0000;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected response is computed from the word-level model and queued before the request is raised.
    task automatic do_op(int d, bit wr, bit rd, logic [15:0] a, logic [31:0] wd, bit scr);
        exp_t e;
        int   n;
        bit   hit;
        bit   done;
        n     = (d == 1) ? W1 + 1 : W0 + 1;
        e.d   = d;
        e.wr  = wr;
        e.addr = a;
        e.we  = 0;
        e.wep = 0;
        e.oe  = 0;
        if (wr) begin
            e.data = wd;
            e.lat  = 2 * n + 1;
            e.we   = 2 * (n - 1);
            e.wep  = 2;
            ref_half[key(d, a, 0)] = wd[15:0];
            ref_half[key(d, a, 1)] = wd[31:16];
            if (FWD) begin
                fwd_v[d] = 1'b1;
                fwd_a[d] = a;
                fwd_d[d] = wd;
            end
        end else begin
            hit    = FWD && fwd_v[d] && (fwd_a[d] == a);
            e.data = hit ? fwd_d[d] : {ref_rd(key(d, a, 1)), ref_rd(key(d, a, 0))};
            e.lat  = hit ? 1 : 2 * n + 1;
            e.oe   = hit ? 0 : 2 * n;
        end
        @(negedge clk);
        rreq[d] = rd;
        wreq[d] = wr;
        areq[d] = a;
        dreq[d] = wd;
        e.acc   = edge_cnt + 1;
        q.push_back(e);
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (scr) begin
                areq[d] = 16'($urandom);
                dreq[d] = $urandom;
            end
            done = (d == 1) ? bus1.ready : bus0.ready;
        end
        rreq[d] = 1'b0;
        wreq[d] = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL dut%0d timeout: ready=0 for 64 cycles, expected 1", d);
        end
    endtask

    // Monitor: SRAM behaviour, strobe activity counters and scoreboard pops on ready.
    initial begin
        int          we_cyc [2];
        int          we_pul [2];
        int          oe_cyc [2];
        int          dq_bad [2];
        bit          we_prev [2];
        exp_t        e;
        logic [17:0] a;
        logic        we, oe, ce, rdy;
        logic [15:0] dqv, rdv;
        logic [31:0] rdd;
        int          k;
        for (int d = 0; d < 2; d++) begin
            we_cyc[d] = 0; we_pul[d] = 0; oe_cyc[d] = 0; dq_bad[d] = 0; we_prev[d] = 1'b1;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                a   = (d == 1) ? sa1 : sa0;
                we  = (d == 1) ? we1 : we0;
                oe  = (d == 1) ? oe1 : oe0;
                ce  = (d == 1) ? ce1 : ce0;
                dqv = (d == 1) ? dq1 : dq0;
                rdv = (d == 1) ? rdv1 : rdv0;
                rdy = (d == 1) ? bus1.ready : bus0.ready;
                rdd = (d == 1) ? bus1.readdata : bus0.readdata;
                k   = (d << 18) | int'(a);
                if (!rst) begin
                    we_cyc[d] = 0; we_pul[d] = 0; oe_cyc[d] = 0; dq_bad[d] = 0; we_prev[d] = 1'b1;
                end else begin
                    if (!ce && !we) mem[k] = dqv;
                    if (!ce && !oe && (dqv !== rdv)) dq_bad[d]++;
                    if (d == 1) rdv1 = mem_rd(k);
                    else        rdv0 = mem_rd(k);
                    if (!we) we_cyc[d]++;
                    if (we_prev[d] && !we) we_pul[d]++;
                    we_prev[d] = we;
                    if (!oe) oe_cyc[d]++;
                    if (rdy) begin
                        if (q.size() == 0 || q[0].d != d) begin
                            checks++;
                            errors++;
                            $display("FAIL dut%0d unexpected_ready: ready=1, expected 0", d);
                        end else begin
                            e = q.pop_front();
                            chk($sformatf("dut%0d latency addr=%h", d, e.addr), edge_cnt - e.acc + 1, e.lat);
                            if (!e.wr) begin
                                chk($sformatf("dut%0d readdata addr=%h", d, e.addr), rdd, e.data);
                            end else begin
                                chk($sformatf("dut%0d mem_lo addr=%h", d, e.addr), mem_rd(key(d, e.addr, 0)), e.data[15:0]);
                                chk($sformatf("dut%0d mem_hi addr=%h", d, e.addr), mem_rd(key(d, e.addr, 1)), e.data[31:16]);
                            end
                            chk($sformatf("dut%0d we_low_cycles", d), we_cyc[d], e.we);
                            chk($sformatf("dut%0d we_pulses", d), we_pul[d], e.wep);
                            chk($sformatf("dut%0d oe_low_cycles", d), oe_cyc[d], e.oe);
                            chk($sformatf("dut%0d dq_contention", d), dq_bad[d], 0);
                        end
                        we_cyc[d] = 0; we_pul[d] = 0; oe_cyc[d] = 0; dq_bad[d] = 0;
                    end
                end
            end
        end
    end

    initial begin
        int          op;
        logic [15:0] a;
        rst  = 1'b0;
        rdv0 = '0;
        rdv1 = '0;
        for (int d = 0; d < 2; d++) begin
            rreq[d] = 1'b0; wreq[d] = 1'b0; areq[d] = '0; dreq[d] = '0;
            fwd_v[d] = 1'b0; fwd_a[d] = '0; fwd_d[d] = '0;
        end
        repeat (2) @(negedge clk);
        chk("dut0 reset_strobes", {27'd0, ce0, oe0, we0, ub0, lb0}, 32'h1f);
        chk("dut1 reset_strobes", {27'd0, ce1, oe1, we1, ub1, lb1}, 32'h1f);
        chk("dut0 reset_ready_readdata", {bus0.ready, bus0.readdata[30:0]}, 32'h0);
        chk("dut1 reset_addr", {14'd0, sa1}, 32'h0);
        rst = 1'b1;

        do_op(0, 1'b1, 1'b0, 16'h0012, 32'hDEADBEEF, 1'b0);
        do_op(0, 1'b0, 1'b1, 16'h0012, 32'h0,        1'b0);
        do_op(0, 1'b1, 1'b1, 16'h0003, 32'h12345678, 1'b0);
        do_op(0, 1'b1, 1'b0, 16'h0040, 32'h0BADCAFE, 1'b0);
        do_op(0, 1'b0, 1'b1, 16'h0040, 32'h0,        1'b0);
        do_op(0, 1'b0, 1'b1, 16'h0041, 32'h0,        1'b0);
        do_op(0, 1'b0, 1'b1, 16'h0003, 32'h0,        1'b1);
        do_op(1, 1'b1, 1'b0, 16'hFFFF, 32'hCAFEF00D, 1'b0);
        do_op(1, 1'b0, 1'b1, 16'h0000, 32'h0,        1'b0);
        do_op(1, 1'b0, 1'b1, 16'hFFFF, 32'h0,        1'b1);

        // Abort a write during the setup cycle of its high half: only the low half lands.
        @(negedge clk);
        wreq[0] = 1'b1;
        areq[0] = 16'h0012;
        dreq[0] = 32'h11112222;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("dut0 abort_strobes", {27'd0, ce0, oe0, we0, ub0, lb0}, 32'h1f);
        chk("dut0 abort_ready", {31'd0, bus0.ready}, 32'h0);
        chk("dut0 abort_readdata", bus0.readdata, 32'h0);
        chk("dut0 abort_addr", {14'd0, sa0}, 32'h0);
        wreq[0] = 1'b0;
        ref_half[key(0, 16'h0012, 0)] = 16'h2222;
        fwd_v[0] = 1'b0;
        fwd_v[1] = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        do_op(0, 1'b0, 1'b1, 16'h0012, 32'h0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 2);
            a  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 7));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(0, op != 0, op != 1, a, $urandom, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 20; i++) begin
            op = $urandom_range(0, 2);
            a  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 3));
            do_op(1, op != 0, op != 1, a, $urandom, 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
        end
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
